// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte streams,
// keeping multi-byte packets contiguous and self-timing each frame.
module uart_tx_arbiter #(
    parameter int  NUM_REQ      = 4,
    parameter int  DW           = 8,
    parameter real CLOCK        = 100.0e6,
    parameter int  BAUD_RATE    = 115200,
    parameter int  FRAME_BITS   = 10,
    parameter int  GAP_CYCLES   = 0,
    parameter int  FRAME_CYCLES = int'(CLOCK / BAUD_RATE) * FRAME_BITS + GAP_CYCLES,
    parameter int  IW           = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ*DW-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]    req_last_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [DW-1:0]         tx_data_o,
    output logic                  tx_byte_ready_o,
    output logic                  tx_t_byte_o,
    output logic [IW-1:0]         owner_o,
    output logic                  busy_o
);

    localparam int             WCW       = $clog2(FRAME_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            lock_q, lock_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            byte_ready_q, byte_ready_d;
    logic            t_byte_q, t_byte_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   sel_idx_s;
    logic            sel_hit_s;
    logic            hs_s;

    // Explicit wrap keeps the rotation correct for non-power-of-2 NUM_REQ.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return IW'(sum);
    endfunction

    // Requester selection: locked owner only, else first valid from ptr.
    always_comb begin
        sel_idx_s = owner_q;
        sel_hit_s = 1'b0;
        if (lock_q) begin
            sel_idx_s = owner_q;
            sel_hit_s = req_valid_i[owner_q];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!sel_hit_s && req_valid_i[rr_index(ptr_q, i)]) begin
                    sel_idx_s = rr_index(ptr_q, i);
                    sel_hit_s = 1'b1;
                end else begin
                    sel_hit_s = sel_hit_s;
                end
            end
        end
    end

    assign hs_s = rst_ni && (state_q == ST_IDLE) && sel_hit_s;

    // Zero-latency ready towards the selected requester.
    always_comb begin
        req_ready_o = {NUM_REQ{1'b0}};
        if (hs_s) begin
            req_ready_o[sel_idx_s] = 1'b1;
        end else begin
            req_ready_o = {NUM_REQ{1'b0}};
        end
    end

    // Sequencer next-state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lock_d       = lock_q;
        wait_cnt_d   = wait_cnt_q;
        data_d       = data_q;
        owner_d      = owner_q;
        byte_ready_d = 1'b0;
        t_byte_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    state_d      = ST_LOAD;
                    data_d       = req_data_i[int'(sel_idx_s)*DW +: DW];
                    owner_d      = sel_idx_s;
                    byte_ready_d = 1'b1;
                    if (req_last_i[sel_idx_s]) begin
                        lock_d = 1'b0;
                        ptr_d  = rr_index(sel_idx_s, 1);
                    end else begin
                        lock_d = 1'b1;
                        ptr_d  = ptr_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d  = ST_START;
                t_byte_d = 1'b1;
            end
            ST_START: begin
                state_d    = ST_WAIT;
                wait_cnt_d = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (wait_cnt_q == {WCW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) || lock_d;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {IW{1'b0}};
            lock_q       <= 1'b0;
            wait_cnt_q   <= {WCW{1'b0}};
            data_q       <= {DW{1'b0}};
            owner_q      <= {IW{1'b0}};
            byte_ready_q <= 1'b0;
            t_byte_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            wait_cnt_q   <= wait_cnt_d;
            data_q       <= data_d;
            owner_q      <= owner_d;
            byte_ready_q <= byte_ready_d;
            t_byte_q     <= t_byte_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_data_o       = data_q;
    assign tx_byte_ready_o = byte_ready_q;
    assign tx_t_byte_o     = t_byte_q;
    assign owner_o         = owner_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queue-driven requesters, a
// transaction-level arbitration model, and a decoupled output monitor.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int FC = 100;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_br;
    logic            tx_tb;
    logic [1:0]      owner;
    logic            busy;

    uart_tx_arbiter #(
        .NUM_REQ(N), .DW(DW), .CLOCK(100.0), .BAUD_RATE(10),
        .FRAME_BITS(10), .GAP_CYCLES(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .tx_data_o(tx_data),
        .tx_byte_ready_o(tx_br), .tx_t_byte_o(tx_tb),
        .owner_o(owner), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int owner;
        int cyc;
    } exp_t;

    int          cyc = 0;
    int          checks = 0;
    int          errs = 0;
    logic [8:0]  bq [N][$];
    logic [N-1:0] hs_mask = '0;
    int          m_ptr = 0;
    int          m_owner = 0;
    int          m_free = 0;
    bit          m_lock = 1'b0;
    exp_t        sb[$];
    int          log_own[$];
    int          log_cyc[$];
    int          exp_log[$];
    bit          br_prev = 1'b0;

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
            if (errs >= 40) finish_sim();
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += bq[k].size();
        return s;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((pending() > 0 || sb.size() > 0 || cyc < m_free) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 5000), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_log();
        chk("grant_count", log_own.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < log_own.size(); i++)
            chk($sformatf("grant_order[%0d]", i), log_own[i], exp_log[i]);
        log_own.delete();
        log_cyc.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester driver: pop on an observed handshake, present the queue front.
    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs_mask[k] && bq[k].size() > 0) void'(bq[k].pop_front());
            if (bq[k].size() > 0) begin
                req_valid[k]          = 1'b1;
                req_last[k]           = bq[k][0][8];
                req_data[k*DW +: DW]  = bq[k][0][7:0];
            end else begin
                req_valid[k] = 1'b0;
            end
        end
    end

    // Arbitration reference model: who should be ready this cycle.
    initial begin
        int       eg;
        int       idx;
        logic [N-1:0] er;
        exp_t     e;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                chk("reset_outputs", {req_ready, tx_data, tx_br, tx_tb, owner, busy}, 64'd0);
                m_ptr = 0; m_owner = 0; m_free = 0; m_lock = 1'b0;
                sb.delete();
                hs_mask = '0;
            end else begin
                hs_mask = req_valid & req_ready;
                eg = -1;
                if (cyc >= m_free) begin
                    if (m_lock) begin
                        if (req_valid[m_owner]) eg = m_owner;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            idx = (m_ptr + i) % N;
                            if (eg < 0 && req_valid[idx]) eg = idx;
                        end
                    end
                end
                er = (eg >= 0) ? (4'b0001 << eg) : 4'b0000;
                chk("req_ready", req_ready, er);
                chk("busy", busy, ((cyc < m_free) || m_lock));
                if (eg >= 0) begin
                    e.data = int'(bq[eg][0][7:0]);
                    e.owner = eg;
                    e.cyc = cyc + 1;
                    sb.push_back(e);
                    m_owner = eg;
                    if (bq[eg][0][8]) begin
                        m_lock = 1'b0;
                        m_ptr = (eg + 1) % N;
                    end else begin
                        m_lock = 1'b1;
                    end
                    m_free = cyc + 3 + FC;
                end
            end
        end
    end

    // Output monitor: compare each uart_tx control pulse with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                br_prev = 1'b0;
            end else begin
                if (br_prev || tx_tb) chk("t_byte_follows_byte_ready", tx_tb, br_prev);
                if (tx_br) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_byte_ready", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("tx_data", tx_data, e.data);
                        chk("owner", owner, e.owner);
                        chk("pulse_cycle", cyc, e.cyc);
                    end
                    log_own.push_back(int'(owner));
                    log_cyc.push_back(cyc);
                end
                br_prev = tx_br;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        errs++;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        finish_sim();
    end

    initial begin
        int n;
        int k;
        int len;
        // Reset with every requester valid, then continuous single-byte traffic.
        for (int r = 0; r < N; r++)
            for (int j = 0; j < 2; j++) bq[r].push_back({1'b1, 8'($urandom)});
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rst_ni = 1'b1;
        wait_drain("drain_round_robin");
        for (int i = 1; i < log_cyc.size(); i++)
            chk("byte_spacing", log_cyc[i] - log_cyc[i-1], FC + 3);
        exp_log = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log();

        @(negedge clk);
        bq[1].push_back({1'b1, 8'hA5});
        wait_drain("drain_single");
        exp_log = '{1};
        check_log();

        // ptr is now 2: req2's packet must win over req0 and stay contiguous.
        @(negedge clk);
        bq[2].push_back({1'b0, 8'h11});
        bq[2].push_back({1'b0, 8'h22});
        bq[2].push_back({1'b1, 8'h33});
        bq[0].push_back({1'b1, 8'($urandom)});
        bq[3].push_back({1'b1, 8'($urandom)});
        wait_drain("drain_packet");
        exp_log = '{2, 2, 2, 3, 0};
        check_log();

        @(negedge clk);
        bq[1].push_back({1'b0, 8'($urandom)});
        bq[0].push_back({1'b1, 8'($urandom)});
        repeat (500) @(negedge clk);
        chk("stall_grants", log_own.size(), 1);
        chk("stall_busy", busy, 1);
        bq[1].push_back({1'b1, 8'($urandom)});
        wait_drain("drain_stall");
        exp_log = '{1, 1, 0};
        check_log();

        repeat (20) begin
            k = $urandom_range(0, N - 1);
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) bq[k].push_back({(j == len - 1), 8'($urandom)});
            repeat ($urandom_range(0, 120)) @(negedge clk);
        end
        wait_drain("drain_random");
        log_own.delete();
        log_cyc.delete();

        // Reset in the middle of a frame; ptr and lock must restart from zero.
        @(negedge clk);
        bq[2].push_back({1'b1, 8'($urandom)});
        n = 0;
        while (!tx_br && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_frame_start", tx_br, 1);
        bq[3].push_back({1'b1, 8'($urandom)});
        bq[1].push_back({1'b1, 8'($urandom)});
        repeat (48) @(negedge clk);
        @(posedge clk);
        #3 rst_ni = 1'b0;
        #1 chk("async_reset_outputs", {req_ready, tx_data, tx_br, tx_tb, owner, busy}, 64'd0);
        log_own.delete();
        log_cyc.delete();
        repeat (3) @(posedge clk);
        #3 rst_ni = 1'b1;
        wait_drain("drain_after_reset");
        exp_log = '{1, 3};
        check_log();

        finish_sim();
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `NUM_REQ` byte-stream requesters.
- Accepts one byte at a time over per-requester valid/ready handshakes and drives the `uart_tx` control pins (`data_i`, `byte_ready_i`, `t_byte_i`).
- `uart_tx` has no busy output, so the arbiter times each frame itself before issuing the next byte.
- A multi-byte packet from one requester is never interleaved with bytes from other requesters.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `DW`, default 8: byte width; matches `uart_tx` `DW`.
- `CLOCK`, default 100e6: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate; matches `uart_tx`.
- `FRAME_BITS`, default 10: bits per frame (start + `DW` + stop).
- `GAP_CYCLES`, default 0: extra idle cycles after each frame.
- `FRAME_CYCLES`, default `int'(CLOCK/BAUD_RATE)*FRAME_BITS + GAP_CYCLES`: length of the WAIT state in cycles (≥1).
- `IW`, default `$clog2(NUM_REQ)`: requester index width.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester byte valid.
- `req_data_i`  in  NUM_REQ*DW  requester k byte at `[k*DW +: DW]`.
- `req_last_i`  in  NUM_REQ  byte is the last of its packet.
- `req_ready_o`  out  NUM_REQ  byte accepted this cycle (one-hot or zero).
- `tx_data_o`  out  DW  to `uart_tx.data_i`.
- `tx_byte_ready_o`  out  1  to `uart_tx.byte_ready_i`; 1-cycle pulse.
- `tx_t_byte_o`  out  1  to `uart_tx.t_byte_i`; 1-cycle pulse.
- `owner_o`  out  IW  index of current or last granted requester.
- `busy_o`  out  1  high when state≠IDLE or a packet lock is held.

## Operation
- FSM states and transitions:
  - IDLE → LOAD on a handshake; otherwise stays in IDLE.
  - LOAD → START, unconditionally.
  - START → WAIT, unconditionally.
  - WAIT → IDLE when `wait_cnt` reaches 0.
- IDLE selection:
  - If `lock`=0: the first requester with valid=1, searching `ptr`, `ptr+1`, … mod `NUM_REQ`.
  - If `lock`=1: only `owner_o` is eligible; all others are ignored even when valid.
- Ready and handshake:
  - `req_ready_o[g]` is combinational: `state==IDLE && g==selected && req_valid_i[g]`.
  - Handshake is valid&ready on the same edge.
- On a handshake:
  - Latch `req_data_i[g]` into `tx_data_o`.
  - Set `owner_o`=g.
  - If `req_last_i[g]`=0: `lock`←1.
  - If `req_last_i[g]`=1: `lock`←0 and `ptr`←(g+1) mod `NUM_REQ`, with explicit wrap for non-power-of-2 `NUM_REQ`.
- LOAD: `tx_byte_ready_o`=1.
- START: `tx_t_byte_o`=1; load `wait_cnt`←`FRAME_CYCLES`-1.
- WAIT: decrement `wait_cnt`; leave when it reaches 0. WAIT therefore lasts exactly `FRAME_CYCLES` cycles.
- `tx_data_o` is held from the handshake until the next handshake.
- Locked owner with valid low: the arbiter idles and holds the lock indefinitely; there is no timeout. Other requesters wait.
- Requester rules (violations undefined):
  - Data and last must stay stable while valid=1 and ready=0.
  - Valid must not drop before ready.
- `wait_cnt` width is `$clog2(FRAME_CYCLES+1)`.
- `ptr` only advances at packet end, so a single-byte packet (last=1) rotates priority immediately.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - state=IDLE, `ptr`=0, `lock`=0, `wait_cnt`=0.
  - `tx_data_o`=0, `tx_byte_ready_o`=0, `tx_t_byte_o`=0, `owner_o`=0, `busy_o`=0.
  - `req_ready_o`=0 while `rst_ni`=0.
- Reset mid-frame: all of the above take effect immediately; the partially sent `uart_tx` frame is the transmitter's concern.
- Per-byte sequence, with the handshake at cycle T:
  - T+1: `tx_byte_ready_o`=1.
  - T+2: `tx_t_byte_o`=1.
  - T+3 … T+2+`FRAME_CYCLES`: WAIT.
  - T+3+`FRAME_CYCLES`: IDLE; earliest next handshake.
- Byte period is `FRAME_CYCLES`+3 cycles.
- Zero-latency grant: a valid seen in IDLE is accepted in the same cycle.
- `busy_o` rises the cycle after the handshake.
- The `tx_byte_ready_o` and `tx_t_byte_o` pulses never overlap and each lasts exactly 1 cycle.

## Test plan
Common setup: `NUM_REQ`=4, `CLOCK`=100, `BAUD_RATE`=10, `FRAME_BITS`=10, `GAP_CYCLES`=0, so `FRAME_CYCLES`=100.

- Reset values: hold `rst_ni`=0 with all valids high → all outputs 0; then release → req0 is granted in the first IDLE cycle.
- Single byte: req1 sends 0xA5 with last=1 →
  - `tx_byte_ready_o` pulses at T+1 with `tx_data_o`=0xA5, and `tx_t_byte_o` pulses at T+2.
  - Next ready is no earlier than T+103.
  - `ptr` becomes 2.
- Round-robin: all 4 requesters send continuous last=1 bytes → grant order 0,1,2,3,0,1; byte spacing is exactly 103 cycles.
- Packet lock: req2 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) while req0 and req3 are valid → bytes 0x11,0x22,0x33 go out consecutively, then req3 is granted, then req0.
- Locked stall: req1 sends its first byte (last=0), then drops valid for 500 cycles while req0 is valid → req0 is never granted and `busy_o` stays 1. req1 then resumes with last=1 → req1 is granted, the lock is released, and req0 is granted next.
- Async reset mid-WAIT: assert `rst_ni` at T+50 → outputs are 0 within the same cycle. After release, `ptr`=0 and `lock`=0, and the pending req3 is granted.
